prirv32_ifetch: RTL and testbench

Instruction fetch front end for the priRV32 core; sits directly upstream of decode/execute and feeds it one 32-bit instruction plus its PC per handshake. Owns the fetch PC and issues word requests to instruction memory over a valid/ready request channel with in-order, variable-latency responses. Buffers returned instructions in a small FIFO and supports a single-cycle redirect (branch/jump/trap) that flushes all in-flight and buffered instructions.

---
 rtl/prirv32_ifetch.sv | 129 ++++++++++++
 tb/tb_prirv32_ifetch.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/prirv32_ifetch.sv
`timescale 1ns/1ps
// priRV32 instruction fetch front end: owns the fetch PC, issues credit-limited
// word requests to instruction memory and buffers returned words with their PCs.
module prirv32_ifetch #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc
);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 2;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] ONE_C   = CW'(1);
   localparam logic [AW-1:0] PINC    = AW'(1);

   logic [31:0]   r_fetch_pc;
   logic          r_hold;
   logic          r_redir_pend;
   logic [31:0]   r_redir_pc;
   logic [31:0]   r_fifo_data [FIFO_DEPTH];
   logic [31:0]   r_fifo_pc   [FIFO_DEPTH];
   logic [AW-1:0] r_fifo_wp, r_fifo_rp;
   logic [CW-1:0] r_fifo_cnt;
   logic [31:0]   r_pq_pc     [FIFO_DEPTH];
   logic [AW-1:0] r_pq_wp, r_pq_rp;
   logic [CW-1:0] r_outstanding;
   logic [CW-1:0] r_discard;

   logic          w_pop, w_can_issue, w_accept, w_rsp_keep, w_rsp_drop;
   logic          w_fifo_we, w_pq_we, w_held_stall;
   logic [CW-1:0] w_used, w_out_next;
   logic [31:0]   w_redir_target;

   assign w_pop          = inst_valid & inst_ready;
   assign w_used         = r_fifo_cnt + r_outstanding - (w_pop ? ONE_C : '0);
   assign w_can_issue    = w_used < DEPTH_C;
   assign imem_req_valid = ~reset & (r_hold | (enable & ~redirect_valid & w_can_issue));
   assign imem_req_addr  = r_fetch_pc;
   assign w_accept       = imem_req_valid & imem_req_ready;
   assign w_held_stall   = imem_req_valid & ~imem_req_ready;
   assign w_rsp_keep     = imem_rsp_valid & (r_discard == '0);
   assign w_rsp_drop     = imem_rsp_valid & (r_discard != '0);
   assign w_out_next     = r_outstanding + (w_accept ? ONE_C : '0) - (imem_rsp_valid ? ONE_C : '0);
   assign w_redir_target = redirect_pc & 32'hFFFF_FFFC;
   assign w_fifo_we      = w_rsp_keep & ~redirect_valid;
   // A request accepted after a pending redirect is already stale, so its PC is never queued.
   assign w_pq_we        = w_accept & ~redirect_valid & ~r_redir_pend;

   assign inst_valid = (r_fifo_cnt != '0);
   assign inst_data  = inst_valid ? r_fifo_data[r_fifo_rp] : '0;
   assign inst_pc    = inst_valid ? r_fifo_pc[r_fifo_rp] : '0;

   always_ff @(posedge clk) begin
      if (w_fifo_we) begin
         r_fifo_data[r_fifo_wp] <= imem_rsp_data;
         r_fifo_pc[r_fifo_wp]   <= r_pq_pc[r_pq_rp];
      end
      if (w_pq_we)
         r_pq_pc[r_pq_wp] <= r_fetch_pc;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_fetch_pc    <= RESET_PC;
         r_hold        <= 1'b0;
         r_redir_pend  <= 1'b0;
         r_redir_pc    <= '0;
         r_fifo_wp     <= '0;
         r_fifo_rp     <= '0;
         r_fifo_cnt    <= '0;
         r_pq_wp       <= '0;
         r_pq_rp       <= '0;
         r_outstanding <= '0;
         r_discard     <= '0;
      end else begin
         r_outstanding <= w_out_next;
         r_hold        <= w_held_stall;
         if (redirect_valid) begin
            r_fifo_wp  <= '0;
            r_fifo_rp  <= '0;
            r_fifo_cnt <= '0;
            r_pq_wp    <= '0;
            r_pq_rp    <= '0;
            r_discard  <= w_out_next;
            // A stalled request must keep its address; the jump lands once it is accepted.
            if (w_held_stall) begin
               r_redir_pend <= 1'b1;
               r_redir_pc   <= w_redir_target;
            end else begin
               r_redir_pend <= 1'b0;
               r_fetch_pc   <= w_redir_target;
            end
         end else begin
            if (w_accept) begin
               if (r_redir_pend) begin
                  r_fetch_pc   <= r_redir_pc;
                  r_redir_pend <= 1'b0;
               end else begin
                  r_fetch_pc <= r_fetch_pc + 32'd4;
               end
            end
            if (w_pq_we)
               r_pq_wp <= r_pq_wp + PINC;
            r_discard <= r_discard + ((w_accept & r_redir_pend) ? ONE_C : '0)
                                   - (w_rsp_drop ? ONE_C : '0);
            if (w_rsp_keep) begin
               r_fifo_wp <= r_fifo_wp + PINC;
               r_pq_rp   <= r_pq_rp + PINC;
            end
            if (w_pop)
               r_fifo_rp <= r_fifo_rp + PINC;
            r_fifo_cnt <= r_fifo_cnt + (w_rsp_keep ? ONE_C : '0) - (w_pop ? ONE_C : '0);
         end
      end
   end
endmodule

// File: tb/tb_prirv32_ifetch.sv
`timescale 1ns/1ps
// Directed bench for prirv32_ifetch: in-order variable-latency memory model
// plus scenario tasks with hand-computed expected PCs and handshakes.
module tb_prirv32_ifetch;
   logic        clk = 1'b0;
   logic        reset, enable, redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        inst_valid, inst_ready;
   logic [31:0] inst_data, inst_pc;

   int n_cmp = 0;
   int n_bad = 0;
   int mem_lat = 1;
   int n_acc = 0;
   int ecnt = 0;
   logic [31:0] mq_addr[$];
   int          mq_due[$];

   always #5 clk = ~clk;

   prirv32_ifetch dut (
      .clk(clk), .reset(reset), .enable(enable),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst_data(inst_data), .inst_pc(inst_pc)
   );

   function automatic logic [31:0] mdata(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   // Memory: response for a request accepted in cycle c appears in cycle c+mem_lat.
   always @(posedge clk) begin
      ecnt = ecnt + 1;
      if (reset) begin
         mq_addr.delete();
         mq_due.delete();
         n_acc = 0;
         imem_rsp_valid <= 1'b0;
         imem_rsp_data  <= '0;
      end else begin
         if (imem_req_valid && imem_req_ready) begin
            mq_addr.push_back(imem_req_addr);
            mq_due.push_back(ecnt + mem_lat - 1);
            n_acc = n_acc + 1;
         end
         if (mq_addr.size() > 0 && mq_due[0] <= ecnt) begin
            imem_rsp_valid <= 1'b1;
            imem_rsp_data  <= mdata(mq_addr[0]);
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
         end else begin
            imem_rsp_valid <= 1'b0;
         end
      end
   end

   task automatic do_reset(input int lat);
      @(negedge clk);
      reset = 1'b1; enable = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      imem_req_ready = 1'b1; inst_ready = 1'b1; mem_lat = lat;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
      imem_req_ready = 1'b1; inst_ready = 1'b1; mem_lat = 1;
      repeat (2) @(negedge clk);
      n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
      n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid); end
      n_cmp++; if (imem_req_addr !== 32'h0) begin n_bad++; $display("FAIL reset_req_addr: got %h want 0", imem_req_addr); end
      n_cmp++; if (inst_data !== 32'h0) begin n_bad++; $display("FAIL reset_inst_data: got %h want 0", inst_data); end
      n_cmp++; if (inst_pc !== 32'h0) begin n_bad++; $display("FAIL reset_inst_pc: got %h want 0", inst_pc); end
   endtask

   task automatic test_stream();
      do_reset(1);
      enable = 1'b1;
      #1;
      n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_bad++; $display("FAIL stream_first_req: got v=%b a=%h want v=1 a=0", imem_req_valid, imem_req_addr); end
      n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL stream_c0_inst_valid: got %b want 0", inst_valid); end
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(4*k)) begin n_bad++; $display("FAIL stream_req c%0d: got v=%b a=%h want v=1 a=%h", k, imem_req_valid, imem_req_addr, 32'(4*k)); end
         n_cmp++; if (inst_valid !== (k >= 2)) begin n_bad++; $display("FAIL stream_inst_valid c%0d: got %b want %b", k, inst_valid, (k >= 2)); end
         if (k >= 2) begin
            n_cmp++; if (inst_pc !== 32'(4*(k-2)) || inst_data !== mdata(32'(4*(k-2)))) begin n_bad++; $display("FAIL stream_inst c%0d: got pc=%h d=%h want pc=%h d=%h", k, inst_pc, inst_data, 32'(4*(k-2)), mdata(32'(4*(k-2)))); end
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset(1);
      enable = 1'b1; inst_ready = 1'b0;
      repeat (10) @(negedge clk);
      n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL bp_req_stopped: got %b want 0", imem_req_valid); end
      n_cmp++; if (n_acc != 2) begin n_bad++; $display("FAIL bp_accepts: got %0d want 2", n_acc); end
      n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin n_bad++; $display("FAIL bp_head: got v=%b pc=%h want v=1 pc=0", inst_valid, inst_pc); end
      n_cmp++; if (imem_req_addr !== 32'h8) begin n_bad++; $display("FAIL bp_fetch_pc: got %h want 8", imem_req_addr); end
      inst_ready = 1'b1;
      #1;
      n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin n_bad++; $display("FAIL bp_resume_req: got v=%b a=%h want v=1 a=8", imem_req_valid, imem_req_addr); end
      for (int j = 1; j <= 3; j++) begin
         @(negedge clk);
         n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'(4*j) || inst_data !== mdata(32'(4*j))) begin n_bad++; $display("FAIL bp_resume_inst %0d: got v=%b pc=%h want v=1 pc=%h", j, inst_valid, inst_pc, 32'(4*j)); end
      end
   endtask

   task automatic test_hold();
      do_reset(1);
      enable = 1'b1;
      repeat (4) @(negedge clk);
      imem_req_ready = 1'b0;
      #1;
      n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10) begin n_bad++; $display("FAIL hold_c4: got v=%b a=%h want v=1 a=10", imem_req_valid, imem_req_addr); end
      n_cmp++; if (inst_pc !== 32'h8) begin n_bad++; $display("FAIL hold_c4_head: got %h want 8", inst_pc); end
      @(negedge clk);
      enable = 1'b0;
      #1;
      n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10) begin n_bad++; $display("FAIL hold_c5: got v=%b a=%h want v=1 a=10", imem_req_valid, imem_req_addr); end
      @(negedge clk);
      n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10) begin n_bad++; $display("FAIL hold_c6: got v=%b a=%h want v=1 a=10", imem_req_valid, imem_req_addr); end
      @(negedge clk);
      imem_req_ready = 1'b1;
      #1;
      n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10) begin n_bad++; $display("FAIL hold_c7: got v=%b a=%h want v=1 a=10", imem_req_valid, imem_req_addr); end
      @(negedge clk);
      n_cmp++; if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h14) begin n_bad++; $display("FAIL hold_c8: got v=%b a=%h want v=0 a=14", imem_req_valid, imem_req_addr); end
      @(negedge clk);
      n_cmp++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== 32'h10) begin n_bad++; $display("FAIL hold_c9: got rv=%b iv=%b pc=%h want rv=0 iv=1 pc=10", imem_req_valid, inst_valid, inst_pc); end
      @(negedge clk);
      n_cmp++; if (inst_valid !== 1'b0 || n_acc != 5) begin n_bad++; $display("FAIL hold_c10: got iv=%b acc=%0d want iv=0 acc=5", inst_valid, n_acc); end
   endtask

   // Redirect with two requests outstanding and 3-cycle memory.
   task automatic test_redirect(input logic [31:0] tgt_in, input logic [31:0] tgt);
      bit ev_req[7]  = '{0, 1, 1, 0, 0, 1, 1};
      int off_req[7] = '{0, 0, 4, 0, 0, 8, 12};
      do_reset(3);
      enable = 1'b1;
      repeat (2) @(negedge clk);
      redirect_valid = 1'b1; redirect_pc = tgt_in;
      #1;
      n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL redir_%h_req_in_redirect: got %b want 0", tgt_in, imem_req_valid); end
      for (int k = 3; k <= 9; k++) begin
         @(negedge clk);
         redirect_valid = 1'b0;
         #1;
         n_cmp++; if (imem_req_valid !== ev_req[k-3]) begin n_bad++; $display("FAIL redir_%h_req_valid c%0d: got %b want %b", tgt_in, k, imem_req_valid, ev_req[k-3]); end
         if (ev_req[k-3]) begin
            n_cmp++; if (imem_req_addr !== tgt + 32'(off_req[k-3])) begin n_bad++; $display("FAIL redir_%h_req_addr c%0d: got %h want %h", tgt_in, k, imem_req_addr, tgt + 32'(off_req[k-3])); end
         end
         n_cmp++; if (inst_valid !== (k >= 8)) begin n_bad++; $display("FAIL redir_%h_inst_valid c%0d: got %b (pc=%h) want %b", tgt_in, k, inst_valid, inst_pc, (k >= 8)); end
         if (k >= 8) begin
            n_cmp++; if (inst_pc !== tgt + 32'(4*(k-8)) || inst_data !== mdata(tgt + 32'(4*(k-8)))) begin n_bad++; $display("FAIL redir_%h_inst c%0d: got pc=%h d=%h want pc=%h", tgt_in, k, inst_pc, inst_data, tgt + 32'(4*(k-8))); end
         end
      end
   endtask

   // Redirect in the cycle a held request is accepted and an older response returns.
   task automatic test_redirect_same_cycle();
      bit ev_req[6]  = '{1, 0, 1, 1, 0, 1};
      int off_req[6] = '{0, 0, 4, 8, 0, 12};
      bit ev_ins[6]  = '{0, 0, 0, 1, 0, 1};
      int off_ins[6] = '{0, 0, 0, 0, 0, 4};
      do_reset(2);
      enable = 1'b1;
      @(negedge clk);
      imem_req_ready = 1'b0;
      #1;
      n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin n_bad++; $display("FAIL same_c1: got v=%b a=%h want v=1 a=4", imem_req_valid, imem_req_addr); end
      @(negedge clk);
      redirect_valid = 1'b1; redirect_pc = 32'h1000; imem_req_ready = 1'b1;
      #1;
      n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin n_bad++; $display("FAIL same_c2_held: got v=%b a=%h want v=1 a=4", imem_req_valid, imem_req_addr); end
      for (int k = 3; k <= 8; k++) begin
         @(negedge clk);
         redirect_valid = 1'b0;
         #1;
         n_cmp++; if (imem_req_valid !== ev_req[k-3]) begin n_bad++; $display("FAIL same_req_valid c%0d: got %b want %b", k, imem_req_valid, ev_req[k-3]); end
         if (ev_req[k-3]) begin
            n_cmp++; if (imem_req_addr !== 32'h1000 + 32'(off_req[k-3])) begin n_bad++; $display("FAIL same_req_addr c%0d: got %h want %h", k, imem_req_addr, 32'h1000 + 32'(off_req[k-3])); end
         end
         n_cmp++; if (inst_valid !== ev_ins[k-3]) begin n_bad++; $display("FAIL same_inst_valid c%0d: got %b (pc=%h) want %b", k, inst_valid, inst_pc, ev_ins[k-3]); end
         if (ev_ins[k-3]) begin
            n_cmp++; if (inst_pc !== 32'h1000 + 32'(off_ins[k-3]) || inst_data !== mdata(32'h1000 + 32'(off_ins[k-3]))) begin n_bad++; $display("FAIL same_inst c%0d: got pc=%h d=%h want pc=%h", k, inst_pc, inst_data, 32'h1000 + 32'(off_ins[k-3])); end
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset(3);
      enable = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      n_cmp++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valids: got rv=%b iv=%b want 0 0", imem_req_valid, inst_valid); end
      n_cmp++; if (imem_req_addr !== 32'h0 || inst_pc !== 32'h0 || inst_data !== 32'h0) begin n_bad++; $display("FAIL midrst_values: got a=%h pc=%h d=%h want 0 0 0", imem_req_addr, inst_pc, inst_data); end
      reset = 1'b0;
      #1;
      n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_bad++; $display("FAIL midrst_restart: got v=%b a=%h want v=1 a=0", imem_req_valid, imem_req_addr); end
      repeat (4) @(negedge clk);
      n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_data !== mdata(32'h0)) begin n_bad++; $display("FAIL midrst_first_inst: got v=%b pc=%h want v=1 pc=0", inst_valid, inst_pc); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_hold();
      test_redirect(32'h200, 32'h200);
      test_redirect(32'h203, 32'h200);
      test_redirect_same_cycle();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
